// File: rtl/breath_sequencer_if.sv
// Signal bundle between the breathing-LED control plane and its consumers.
// The sequencer (master) takes the raw speed buttons and drives the ramp,
// colour and speed outputs. The PWM stage and indicators (slave) see the
// opposite directions.
//   btn_inc, btn_dec : raw push buttons, asynchronous to the clock
//   brightness       : ramp level, 0..MAX_BRIGHTNESS
//   color_idx        : palette index
//   speed_mode       : 0 = slowest .. 3 = fastest breath
//   led_speed        : one-hot speed indicator (1 << speed_mode)
//   cycle_done       : one-clock pulse when a breath completes
interface breath_sequencer_if;
   logic       btn_inc;
   logic       btn_dec;
   logic [7:0] brightness;
   logic [2:0] color_idx;
   logic [1:0] speed_mode;
   logic [3:0] led_speed;
   logic       cycle_done;

   modport master (
      input  btn_inc, btn_dec,
      output brightness, color_idx, speed_mode, led_speed, cycle_done
   );

   modport slave (
      output btn_inc, btn_dec,
      input  brightness, color_idx, speed_mode, led_speed, cycle_done
   );
endinterface

// File: rtl/breath_sequencer.sv
// Control plane for the rainbow breathing LED.
// Debounces the speed buttons, holds one of four breathing speeds, and runs a
// triangular brightness ramp. The colour advances once per completed breath,
// so a colour change always happens at darkness.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : breath_sequencer_if master (buttons in, ramp/colour/speed out)
//
// state | meaning
// ------+-----------------------------------------------
// RISE  | brightness climbs one step per tick up to peak
// FALL  | brightness drops one step per tick down to 0
// DARK  | brightness held at 0 for DARK_STEPS ticks
module breath_sequencer #(
   parameter int CLK_FREQ        = 125000000,
   parameter int MAX_BRIGHTNESS  = 100,
   parameter int BASE_STEP       = 1250000,
   parameter int DEBOUNCE_CYCLES = 1250000,
   parameter int NUM_COLORS      = 7,
   parameter int DARK_STEPS      = 0
) (
   input logic                clk,
   input logic                rst_n,
   breath_sequencer_if.master bus
);

   // A degenerate parameter set collapses to a one-cycle debounce instead of
   // an unreachable terminal count.
   localparam logic [31:0] DB_LAST =
      (CLK_FREQ > 0 && DEBOUNCE_CYCLES > 0) ? 32'(DEBOUNCE_CYCLES - 1) : 32'd0;
   localparam logic [7:0]  PEAK       = 8'(MAX_BRIGHTNESS);
   localparam logic [2:0]  LAST_COLOR = 3'(NUM_COLORS - 1);
   // Only compared while in DARK, which is unreachable when DARK_STEPS is 0.
   localparam logic [31:0] DARK_LAST  = 32'(DARK_STEPS - 1);

   typedef enum logic [1:0] {RISE, FALL, DARK} ramp_state_t;

   // Button path, index 0 = inc, index 1 = dec.
   logic [1:0]  raw;
   logic [1:0]  sync_a;
   logic [1:0]  sync_b;
   logic [1:0]  accepted;
   logic [1:0]  press;
   logic [31:0] db_cnt [2];

   assign raw = {bus.btn_dec, bus.btn_inc};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_a    <= '0;
         sync_b    <= '0;
         accepted  <= '0;
         press     <= '0;
         db_cnt[0] <= '0;
         db_cnt[1] <= '0;
      end else begin
         sync_a <= raw;
         sync_b <= sync_a;
         press  <= '0;
         for (int i = 0; i < 2; i++) begin
            if (sync_b[i] != accepted[i]) begin
               if (db_cnt[i] == DB_LAST) begin
                  db_cnt[i]   <= '0;
                  accepted[i] <= sync_b[i];
                  // Only the press edge is reported; release is silent.
                  press[i]    <= sync_b[i];
               end else begin
                  db_cnt[i] <= db_cnt[i] + 32'd1;
               end
            end else begin
               db_cnt[i] <= '0;
            end
         end
      end
   end

   // Speed selection, saturating at both ends.
   logic [1:0] speed_mode;
   logic [1:0] speed_next;
   logic [3:0] led_speed;

   always_comb begin
      speed_next = speed_mode;
      if (press[0] && !press[1] && speed_mode != 2'd3) begin
         speed_next = speed_mode + 2'd1;
      end else if (press[1] && !press[0] && speed_mode != 2'd0) begin
         speed_next = speed_mode - 2'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         speed_mode <= 2'd2;
         led_speed  <= 4'b0100;
      end else begin
         speed_mode <= speed_next;
         led_speed  <= 4'b0001 << speed_next;
      end
   end

   // Step timer; a speed change restarts the current step from zero.
   logic [31:0] timer;
   logic [31:0] step_last;
   logic        tick;

   assign step_last = (32'(BASE_STEP) >> speed_mode) - 32'd1;
   assign tick      = (timer == step_last);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timer <= '0;
      end else if (speed_next != speed_mode || tick) begin
         timer <= '0;
      end else begin
         timer <= timer + 32'd1;
      end
   end

   // Ramp FSM.
   ramp_state_t state, state_next;
   logic [7:0]  bright, bright_next;
   logic [2:0]  color, color_next;
   logic        done, done_next;
   logic [31:0] dark_cnt, dark_next;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= RISE;
         bright   <= '0;
         color    <= '0;
         done     <= 1'b0;
         dark_cnt <= '0;
      end else begin
         state    <= state_next;
         bright   <= bright_next;
         color    <= color_next;
         done     <= done_next;
         dark_cnt <= dark_next;
      end
   end

   always_comb begin
      state_next  = state;
      bright_next = bright;
      color_next  = color;
      done_next   = 1'b0;
      dark_next   = dark_cnt;
      if (tick) begin
         case (state)
            RISE: begin
               bright_next = bright + 8'd1;
               if (bright + 8'd1 == PEAK) begin
                  state_next = FALL;
               end
            end
            FALL: begin
               bright_next = bright - 8'd1;
               if (bright == 8'd1) begin
                  done_next  = 1'b1;
                  color_next = (color == LAST_COLOR) ? 3'd0 : color + 3'd1;
                  state_next = (DARK_STEPS > 0) ? DARK : RISE;
               end
            end
            DARK: begin
               if (dark_cnt == DARK_LAST) begin
                  dark_next  = '0;
                  state_next = RISE;
               end else begin
                  dark_next = dark_cnt + 32'd1;
               end
            end
            default: state_next = RISE;
         endcase
      end
   end

   assign bus.brightness = bright;
   assign bus.color_idx  = color;
   assign bus.speed_mode = speed_mode;
   assign bus.led_speed  = led_speed;
   assign bus.cycle_done = done;

endmodule

// File: tb/tb_breath_sequencer.sv
// Self-checking bench for breath_sequencer. A behavioural model predicts every
// output each cycle: ramp level and colour are computed from the total number
// of step ticks, ticks from elapsed cycles since reset or the last speed change,
// and button presses from run lengths of the synchronised button level.
module tb_breath_sequencer;
   localparam int BASE_STEP = 8;
   localparam int MAX_B     = 4;
   localparam int DEB       = 4;
   localparam int NC        = 3;
   localparam int DARK      = 0;
   localparam int PERIOD    = 2 * MAX_B + DARK;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   breath_sequencer_if bus();

   breath_sequencer #(
      .CLK_FREQ       (125000000),
      .MAX_BRIGHTNESS (MAX_B),
      .BASE_STEP      (BASE_STEP),
      .DEBOUNCE_CYCLES(DEB),
      .NUM_COLORS     (NC),
      .DARK_STEPS     (DARK)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Model state.
   int m_ticks;
   int m_elapsed;
   int m_speed;
   bit m_done;
   bit m_press [2];
   bit m_d1    [2];
   bit m_d2    [2];
   bit m_acc   [2];
   int m_run   [2];

   int done_count;
   int done_colors [$];

   function automatic int exp_bright(input int n);
      int p;
      p = n % PERIOD;
      if (p <= MAX_B) return p;
      if (p < 2 * MAX_B) return 2 * MAX_B - p;
      return 0;
   endfunction

   function automatic int breaths_done(input int n);
      if (n < 2 * MAX_B) return 0;
      return (n - 2 * MAX_B) / PERIOD + 1;
   endfunction

   function automatic void model_reset();
      m_ticks   = 0;
      m_elapsed = 0;
      m_speed   = 2;
      m_done    = 1'b0;
      for (int b = 0; b < 2; b++) begin
         m_press[b] = 1'b0;
         m_d1[b]    = 1'b0;
         m_d2[b]    = 1'b0;
         m_acc[b]   = 1'b0;
         m_run[b]   = 0;
      end
   endfunction

   // Advance the model across one rising clock edge.
   function automatic void model_edge(input bit raw_inc, input bit raw_dec);
      int step;
      int new_speed;
      bit raw [2];
      bit np  [2];
      bit sv;
      raw[0] = raw_inc;
      raw[1] = raw_dec;
      step = BASE_STEP >> m_speed;
      m_elapsed++;
      m_done = 1'b0;
      if (m_elapsed % step == 0) begin
         m_ticks++;
         m_done = (m_ticks >= 2 * MAX_B) && ((m_ticks - 2 * MAX_B) % PERIOD == 0);
      end
      new_speed = m_speed;
      if (m_press[0] && !m_press[1]) new_speed = (m_speed < 3) ? m_speed + 1 : 3;
      else if (m_press[1] && !m_press[0]) new_speed = (m_speed > 0) ? m_speed - 1 : 0;
      if (new_speed != m_speed) begin
         m_speed   = new_speed;
         m_elapsed = 0;
      end
      // The synchroniser delays the raw level by two edges.
      for (int b = 0; b < 2; b++) begin
         np[b] = 1'b0;
         sv = m_d2[b];
         if (sv != m_acc[b]) begin
            m_run[b]++;
            if (m_run[b] == DEB) begin
               m_acc[b] = sv;
               m_run[b] = 0;
               np[b]    = sv;
            end
         end else begin
            m_run[b] = 0;
         end
         m_d2[b] = m_d1[b];
         m_d1[b] = raw[b];
      end
      m_press[0] = np[0];
      m_press[1] = np[1];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      model_edge(bus.btn_inc, bus.btn_dec);
      @(negedge clk);
      chk("brightness", bus.brightness, exp_bright(m_ticks));
      chk("color_idx",  bus.color_idx,  breaths_done(m_ticks) % NC);
      chk("speed_mode", bus.speed_mode, m_speed);
      chk("led_speed",  bus.led_speed,  1 << m_speed);
      chk("cycle_done", bus.cycle_done, m_done);
      if (bus.cycle_done === 1'b1) begin
         done_count++;
         done_colors.push_back(int'(bus.color_idx));
      end
   endtask

   task automatic run(input int n);
      repeat (n) cyc();
   endtask

   task automatic press(input bit inc, input bit dec, input int hold, input int gap);
      bus.btn_inc = inc;
      bus.btn_dec = dec;
      run(hold);
      bus.btn_inc = 1'b0;
      bus.btn_dec = 1'b0;
      run(gap);
   endtask

   task automatic chk_reset_values(input string tag);
      chk({tag, "_brightness"}, bus.brightness, 0);
      chk({tag, "_color"},      bus.color_idx,  0);
      chk({tag, "_speed"},      bus.speed_mode, 2);
      chk({tag, "_led"},        bus.led_speed,  4'b0100);
      chk({tag, "_done"},       bus.cycle_done, 0);
   endtask

   initial begin
      int found;
      int gap;
      int prevb;
      int sel;

      bus.btn_inc = 1'b0;
      bus.btn_dec = 1'b0;
      model_reset();
      done_count = 0;

      // Reset and release.
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk_reset_values("reset");

      // Mode 2 ramp: 0->4 in 8 clk, 4->0 in 8 clk, then three breaths total.
      run(7);
      @(posedge clk);
      model_edge(bus.btn_inc, bus.btn_dec);
      @(negedge clk);
      chk("peak_after_8", bus.brightness, 4);
      run(8);
      chk("dark_after_16", bus.brightness, 0);
      chk("done_at_dark",  bus.cycle_done, 1);
      chk("color_first",   bus.color_idx,  1);
      run(1);
      chk("done_one_clk",  bus.cycle_done, 0);
      run(31);
      chk("done_count_3", done_count, 3);
      chk("color_seq_0", (done_colors.size() > 0) ? done_colors[0] : -1, 1);
      chk("color_seq_1", (done_colors.size() > 1) ? done_colors[1] : -1, 2);
      chk("color_seq_2", (done_colors.size() > 2) ? done_colors[2] : -1, 0);

      // Short glitch is rejected, a held press speeds up, saturating at 3.
      press(1'b1, 1'b0, 3, 12);
      chk("glitch_speed", bus.speed_mode, 2);
      press(1'b1, 1'b0, 12, 12);
      chk("inc_speed", bus.speed_mode, 3);
      chk("inc_led",   bus.led_speed,  4'b1000);
      press(1'b1, 1'b0, 12, 12);
      chk("inc_sat", bus.speed_mode, 3);

      // Four dec presses: 2, 1, 0, 0.
      press(1'b0, 1'b1, 12, 12);
      chk("dec_1", bus.speed_mode, 2);
      press(1'b0, 1'b1, 12, 12);
      chk("dec_2", bus.speed_mode, 1);
      press(1'b0, 1'b1, 12, 12);
      chk("dec_3", bus.speed_mode, 0);
      press(1'b0, 1'b1, 12, 12);
      chk("dec_sat", bus.speed_mode, 0);
      chk("dec_led", bus.led_speed,  4'b0001);

      // Step spacing in mode 0.
      prevb = int'(bus.brightness);
      found = 0;
      for (int i = 0; i < 20 && found == 0; i++) begin
         cyc();
         if (int'(bus.brightness) != prevb) found = 1;
      end
      chk("step_align", found, 1);
      prevb = int'(bus.brightness);
      found = 0;
      gap   = 0;
      for (int i = 0; i < 20 && found == 0; i++) begin
         cyc();
         gap++;
         if (int'(bus.brightness) != prevb) found = 1;
      end
      chk("step_spacing", gap, 8);

      // Both buttons together: no change.
      press(1'b1, 1'b1, 12, 12);
      chk("both_no_change", bus.speed_mode, 0);

      // Randomised button activity against the model.
      for (int k = 0; k < 40; k++) begin
         sel = int'($urandom_range(0, 2));
         press(sel != 1, sel != 0, int'($urandom_range(1, 10)), int'($urandom_range(1, 10)));
      end
      run(12);

      // Reset mid-FALL at brightness 2.
      found = 0;
      for (int i = 0; i < 600 && found == 0; i++) begin
         cyc();
         if (m_ticks % PERIOD == 2 * MAX_B - 2) found = 1;
      end
      chk("reach_fall_2", found, 1);
      chk("pre_reset_bright", bus.brightness, 2);
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset_values("async_reset");
      repeat (3) @(negedge clk);
      chk_reset_values("held_reset");
      rst_n = 1'b1;
      model_reset();
      run(2);
      chk("restart_rise", bus.brightness, 1);
      run(18);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
